// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-phase traffic controller: FSM state
// encoding, per-phase lamp decode and parameter legality check.
package traffic_pkg;

    typedef enum logic [1:0] {
        S_GRN = 2'd0,
        S_YLW = 2'd1,
        S_AR  = 2'd2
    } state_t;

    // Lamp triple {grn, ylw, red} for one phase; only the owning phase leaves red.
    function automatic logic [2:0] lamp_decode(input state_t st, input logic owner);
        if (!owner) begin
            return 3'b001;
        end
        case (st)
            S_GRN:   return 3'b100;
            S_YLW:   return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic bit params_ok(input int nph, input int tw, input int pre,
                                     input int gmin, input int gmax,
                                     input int ylw, input int ar);
        return (nph >= 2) && (nph <= 8) && (tw >= 1) && (tw <= 31) && (pre >= 1) &&
               (gmin >= 1) && (gmin <= gmax) && (gmax < (1 << tw)) &&
               (ylw >= 1) && (ylw < (1 << tw)) && (ar >= 1) && (ar < (1 << tw));
    endfunction

endpackage

// File: rtl/tc_rr_pick.sv
// Round-robin selector: first pending phase after cur (wrapping back to cur),
// or cur+1 when nothing is pending.
module tc_rr_pick #(
    parameter  int NPH = 2,
    localparam int PW  = $clog2(NPH)
) (
    input  logic [NPH-1:0] pend,
    input  logic [PW-1:0]  cur,
    output logic [PW-1:0]  next_ph,
    output logic           found
);

    logic [PW-1:0]  ridx [NPH];
    logic [NPH-1:0] rot;

    // rot[k] is the pending bit of the phase k+1 positions after cur
    for (genvar gi = 0; gi < NPH; gi++) begin : g_rot
        assign ridx[gi] = PW'((int'(cur) + gi + 1) % NPH);
        assign rot[gi]  = pend[ridx[gi]];
    end

    always_comb begin
        next_ph = ridx[0];
        for (int k = NPH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                next_ph = ridx[k];
            end
        end
    end

    assign found = |pend;

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-phase traffic-light controller: green/yellow/all-red per phase with a tick
// prescaler, fixed-time or demand-actuated round-robin hand-off.
module traffic_ctrl_n
    import traffic_pkg::*;
#(
    parameter int NPH    = 2,
    parameter int TW     = 8,
    parameter int PRE    = 16,
    parameter int T_GMIN = 8,
    parameter int T_GMAX = 32,
    parameter int T_YLW  = 4,
    parameter int T_AR   = 1
) (
    input  logic                    CK,
    input  logic                    CLR,
    input  logic                    TEST,
    input  logic                    FM,
    input  logic [NPH-1:0]          DEMAND,
    output logic [NPH-1:0]          GRN,
    output logic [NPH-1:0]          YLW,
    output logic [NPH-1:0]          RED,
    output logic [$clog2(NPH)-1:0]  PHASE
);

    localparam int PW   = $clog2(NPH);
    localparam int PREW = (PRE > 1) ? $clog2(PRE) : 1;

    localparam logic [TW-1:0]   GMIN_LAST = TW'(T_GMIN - 1);
    localparam logic [TW-1:0]   GMAX_LAST = TW'(T_GMAX - 1);
    localparam logic [TW-1:0]   YLW_LAST  = TW'(T_YLW - 1);
    localparam logic [TW-1:0]   AR_LAST   = TW'(T_AR - 1);
    localparam logic [PREW-1:0] PRE_LAST  = PREW'(PRE - 1);

    if (!params_ok(NPH, TW, PRE, T_GMIN, T_GMAX, T_YLW, T_AR)) begin : g_param_err
        $error("traffic_ctrl_n: illegal parameter set");
    end

    state_t          state_reg, state_next;
    logic [PW-1:0]   cur_reg, cur_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [PREW-1:0] pre_reg, pre_next;
    logic [NPH-1:0]  pending_reg, pending_next;
    logic [NPH-1:0]  grn_reg, ylw_reg, red_reg;
    logic [NPH-1:0]  grn_next, ylw_next, red_next;
    logic [NPH-1:0]  grn_rst, ylw_rst, red_rst;
    logic [NPH-1:0]  cur_oh, next_oh;
    logic [PW-1:0]   pick, succ;
    logic            found, tick, enter_grn;

    tc_rr_pick #(.NPH(NPH)) u_pick (
        .pend    (pending_reg),
        .cur     (cur_reg),
        .next_ph (pick),
        .found   (found)
    );

    for (genvar gi = 0; gi < NPH; gi++) begin : g_phase
        logic [2:0] lamp_next;
        logic [2:0] lamp_rst;
        assign cur_oh[gi]   = (cur_reg == PW'(gi));
        assign next_oh[gi]  = (cur_next == PW'(gi));
        assign lamp_next    = lamp_decode(state_next, next_oh[gi]);
        assign lamp_rst     = lamp_decode(S_GRN, gi == 0);
        assign grn_next[gi] = lamp_next[2];
        assign ylw_next[gi] = lamp_next[1];
        assign red_next[gi] = lamp_next[0];
        assign grn_rst[gi]  = lamp_rst[2];
        assign ylw_rst[gi]  = lamp_rst[1];
        assign red_rst[gi]  = lamp_rst[0];
    end

    always_comb begin
        tick     = 1'b1;
        pre_next = '0;
        if (!TEST) begin
            tick     = (pre_reg == PRE_LAST);
            pre_next = tick ? '0 : pre_reg + 1'b1;
        end
    end

    assign succ = (cur_reg == PW'(NPH - 1)) ? '0 : cur_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        timer_next = timer_reg;
        case (state_reg)
            S_GRN: begin
                if (tick) begin
                    if (!FM ? (timer_reg == GMAX_LAST)
                            : ((timer_reg >= GMIN_LAST) && (|(pending_reg & ~cur_oh)))) begin
                        state_next = S_YLW;
                        timer_next = '0;
                    end else if (timer_reg != GMAX_LAST) begin
                        // saturating: demand-mode green rests at the max count
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end
            S_YLW: begin
                if (tick) begin
                    if (timer_reg == YLW_LAST) begin
                        state_next = S_AR;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end
            S_AR: begin
                if (tick) begin
                    if (timer_reg == AR_LAST) begin
                        state_next = S_GRN;
                        timer_next = '0;
                        cur_next   = (FM && found) ? pick : succ;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_GRN;
                timer_next = '0;
            end
        endcase
    end

    // Clearing the newly served phase overrides a simultaneous demand for it
    always_comb begin
        enter_grn    = (state_reg == S_AR) && (state_next == S_GRN);
        pending_next = (pending_reg | (DEMAND & ~((state_reg == S_GRN) ? cur_oh : '0)))
                       & ~(enter_grn ? next_oh : '0);
    end

    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            state_reg   <= S_GRN;
            cur_reg     <= '0;
            timer_reg   <= '0;
            pre_reg     <= '0;
            pending_reg <= '0;
            grn_reg     <= grn_rst;
            ylw_reg     <= ylw_rst;
            red_reg     <= red_rst;
        end else begin
            state_reg   <= state_next;
            cur_reg     <= cur_next;
            timer_reg   <= timer_next;
            pre_reg     <= pre_next;
            pending_reg <= pending_next;
            grn_reg     <= grn_next;
            ylw_reg     <= ylw_next;
            red_reg     <= red_next;
        end
    end

    assign GRN   = grn_reg;
    assign YLW   = ylw_reg;
    assign RED   = red_reg;
    assign PHASE = cur_reg;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Bench for traffic_ctrl_n (NPH=4): directed timing scenarios plus randomized
// demand, checked per cycle against a phase/segment reference model.
module tb_traffic_ctrl_n;

    localparam int NPH    = 4;
    localparam int TW     = 8;
    localparam int PRE    = 16;
    localparam int T_GMIN = 8;
    localparam int T_GMAX = 32;
    localparam int T_YLW  = 4;
    localparam int T_AR   = 1;
    localparam int PW     = $clog2(NPH);
    localparam int OW     = 3 * NPH + PW;

    logic           CK = 1'b0;
    logic           CLR = 1'b1;
    logic           TEST = 1'b1;
    logic           FM = 1'b0;
    logic [NPH-1:0] DEMAND = '0;
    logic [NPH-1:0] GRN, YLW, RED;
    logic [PW-1:0]  PHASE;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt      = 0;
    logic [OW-1:0] exp_q [$];

    always #5 CK = ~CK;

    traffic_ctrl_n #(
        .NPH(NPH), .TW(TW), .PRE(PRE), .T_GMIN(T_GMIN),
        .T_GMAX(T_GMAX), .T_YLW(T_YLW), .T_AR(T_AR)
    ) dut (
        .CK(CK), .CLR(CLR), .TEST(TEST), .FM(FM), .DEMAND(DEMAND),
        .GRN(GRN), .YLW(YLW), .RED(RED), .PHASE(PHASE)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Lamp word {GRN,YLW,RED,PHASE} for segment 0=green 1=yellow 2=all-red
    function automatic logic [OW-1:0] exp_lamps(input int seg, input int ph);
        logic [NPH-1:0] g, y, r;
        g = '0; y = '0; r = '1;
        if (seg == 0) begin g[ph] = 1'b1; r[ph] = 1'b0; end
        else if (seg == 1) begin y[ph] = 1'b1; r[ph] = 1'b0; end
        return {g, y, r, PW'(ph)};
    endfunction

    // Reference model: segment, owning phase, ticks elapsed, demand set
    int m_seg = 0, m_ph = 0, m_el = 0, m_pre = 0;
    logic [NPH-1:0] m_pend = '0;

    always @(posedge CK) begin : model
        logic [NPH-1:0] old_pend;
        bit tk, others, done;
        int nxt;
        if (CLR) begin
            m_seg = 0; m_ph = 0; m_el = 0; m_pre = 0; m_pend = '0;
        end else begin
            tk = TEST || (m_pre == PRE - 1);
            m_pre = tk ? 0 : m_pre + 1;
            old_pend = m_pend;
            others = 0;
            for (int j = 0; j < NPH; j++)
                if (j != m_ph && old_pend[j]) others = 1;
            for (int j = 0; j < NPH; j++)
                if (DEMAND[j] && !(m_seg == 0 && j == m_ph)) m_pend[j] = 1'b1;
            if (tk) begin
                case (m_seg)
                    0:       done = FM ? ((m_el + 1 >= T_GMIN) && others) : (m_el + 1 >= T_GMAX);
                    1:       done = (m_el + 1 >= T_YLW);
                    default: done = (m_el + 1 >= T_AR);
                endcase
                if (!done) begin
                    m_el++;
                end else begin
                    m_el = 0;
                    if (m_seg == 2) begin
                        nxt = (m_ph + 1) % NPH;
                        if (FM)
                            for (int k = NPH; k >= 1; k--)
                                if (old_pend[(m_ph + k) % NPH]) nxt = (m_ph + k) % NPH;
                        m_ph = nxt;
                        m_pend[nxt] = 1'b0;
                        m_seg = 0;
                    end else begin
                        m_seg++;
                    end
                end
            end
        end
        exp_q.push_back(exp_lamps(m_seg, m_ph));
    end

    // Monitor: every cycle presents a lamp word
    always @(posedge CK) begin : monitor
        logic [OW-1:0] e;
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: no expected entry (t=%0t)", $time);
        end else begin
            e = exp_q.pop_front();
            if ({GRN, YLW, RED, PHASE} !== e) begin
                n_fail++;
                $display("FAIL scoreboard: got %b expected %b (t=%0t)", {GRN, YLW, RED, PHASE}, e, $time);
            end
        end
    end

    task automatic step();
        @(posedge CK);
        #2;
        cnt++;
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        DEMAND = '0;
        repeat (3) step();
        CLR = 1'b0;
        cnt = 0;
    endtask

    task automatic pulse(input logic [NPH-1:0] d);
        DEMAND = d;
        step();
        DEMAND = '0;
    endtask

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stim
        int t_y0, t_ar, t_g1, t_g2, t_back, bad, last_ph;
        int ord [$];

        // 1: fixed time, TEST=1
        TEST = 1'b1; FM = 1'b0;
        CLR = 1'b1;
        repeat (3) step();
        check("rst_grn", int'(GRN), 1);
        check("rst_ylw", int'(YLW), 0);
        check("rst_red", int'(RED), 14);
        check("rst_phase", int'(PHASE), 0);
        CLR = 1'b0; cnt = 0;
        t_y0 = -1; t_ar = -1; t_g1 = -1; t_g2 = -1; t_back = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (t_y0 < 0 && YLW[0]) t_y0 = cnt;
            if (t_ar < 0 && RED == 4'hF) t_ar = cnt;
            if (t_g1 < 0 && GRN[1]) t_g1 = cnt;
            if (t_g2 < 0 && GRN[2]) t_g2 = cnt;
            if (t_back < 0 && t_g1 > 0 && GRN[0]) t_back = cnt;
        end
        check("fix_ylw0_cycle", t_y0, 32);
        check("fix_allred_cycle", t_ar, 36);
        check("fix_grn1_cycle", t_g1, 37);
        check("fix_grn2_cycle", t_g2, 74);
        check("fix_back0_cycle", t_back, 148);

        // 2: prescaler active
        TEST = 1'b0;
        do_reset();
        t_y0 = -1;
        for (int i = 0; i < 600 && t_y0 < 0; i++) begin
            step();
            if (YLW[0]) t_y0 = cnt;
        end
        check("pre_ylw0_cycle", t_y0, 512);

        // 3: demand mode rests, then DEMAND[2] skips phases 1 and 3
        TEST = 1'b1; FM = 1'b1;
        do_reset();
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (GRN != 4'b0001) bad++;
        end
        check("rest_ph0_bad_cycles", bad, 0);
        pulse(4'b0100);
        t_y0 = -1; t_g2 = -1; bad = 0;
        for (int i = 0; i < 50 && t_g2 < 0; i++) begin
            step();
            if (t_y0 < 0 && YLW[0]) t_y0 = cnt;
            if (GRN[1] || GRN[3]) bad++;
            if (GRN[2]) t_g2 = cnt;
        end
        check("dm_ylw0_cycle", t_y0, 202);
        check("dm_grn2_cycle", t_g2, 207);
        check("dm_phase2", int'(PHASE), 2);
        check("dm_grn_0100", int'(GRN), 4);
        check("dm_skipped_green", bad, 0);

        // 4: minimum green, then two pending phases served in order
        do_reset();
        step(); step();
        pulse(4'b1000);
        t_y0 = -1;
        for (int i = 0; i < 40 && t_y0 < 0; i++) begin
            step();
            if (YLW[0]) t_y0 = cnt;
        end
        check("gmin_ylw0_cycle", t_y0, 8);
        pulse(4'b0010);
        last_ph = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (GRN != 0 && int'(PHASE) != last_ph) begin
                ord.push_back(int'(PHASE));
                last_ph = int'(PHASE);
            end
        end
        check("order_count", ord.size(), 2);
        check("order_first", (ord.size() > 0) ? ord[0] : -1, 1);
        check("order_second", (ord.size() > 1) ? ord[1] : -1, 3);

        // DEMAND for the phase already green is ignored
        pulse(4'b1000);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (GRN != 4'b1000) bad++;
        end
        check("own_demand_ignored", bad, 0);

        // DEMAND[1] held across its own green entry leaves no pending bit
        pulse(4'b0010);
        for (int i = 0; i < 40 && RED != 4'hF; i++) step();
        check("wait_allred", int'(RED), 15);
        DEMAND = 4'b0010;
        step(); step();
        DEMAND = '0;
        check("entry_grn1", int'(GRN), 2);
        pulse(4'b0100);
        for (int i = 0; i < 40 && !GRN[2]; i++) step();
        check("wait_grn2", int'(GRN), 4);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (GRN != 4'b0100) bad++;
        end
        check("entry_clear_rest2", bad, 0);

        // 5: asynchronous CLR during yellow of phase 1
        pulse(4'b0010);
        for (int i = 0; i < 40 && !GRN[1]; i++) step();
        pulse(4'b0001);
        for (int i = 0; i < 40 && !YLW[1]; i++) step();
        check("wait_ylw1", int'(YLW), 2);
        CLR = 1'b1;
        #1;
        check("async_grn", int'(GRN), 1);
        check("async_ylw", int'(YLW), 0);
        check("async_red", int'(RED), 14);
        check("async_phase", int'(PHASE), 0);
        do_reset();
        repeat (20) step();
        check("restart_grn", int'(GRN), 1);
        check("restart_phase", int'(PHASE), 0);

        // 6: randomized demand, mode, prescaler and reset
        for (int i = 0; i < 4000; i++) begin
            DEMAND = '0;
            for (int j = 0; j < NPH; j++)
                if ($urandom_range(0, 29) == 0) DEMAND[j] = 1'b1;
            if ($urandom_range(0, 299) == 0) FM = ~FM;
            if (i % 400 == 0) TEST = ($urandom_range(0, 3) != 0);
            CLR = ($urandom_range(0, 999) == 0);
            step();
        end
        CLR = 1'b0;
        DEMAND = '0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_n.md
# traffic_ctrl_n

Parametrised N-phase traffic-light controller: the next generation of the two-road GRN/YLW/RED controller, generalised to NPH signal phases with parameter-set durations, a tick prescaler, and a demand-actuated mode driven by per-phase detector inputs. It sits between the approach detectors and the lamp drivers. It runs one fixed green → yellow → all-red sequence per phase and hands off to the next phase, chosen round-robin.

## Interface
- NPH, 2: number of phases, 2..8
- TW, 8: phase-timer width in bits
- PRE, 16: clocks per timer tick, ≥1
- T_GMIN, 8: minimum green, in ticks (demand mode)
- T_GMAX, 32: fixed/maximum green, in ticks; 1 ≤ T_GMIN ≤ T_GMAX < 2^TW
- T_YLW, 4: yellow duration in ticks, ≥1
- T_AR, 1: all-red clearance in ticks, ≥1
- CK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high
- TEST  in  1  1 = one tick every CK, prescaler bypassed
- FM  in  1  0 = fixed-time round robin; 1 = demand-actuated
- DEMAND  in  NPH  per-phase detector, level or single-cycle pulse
- GRN  out  NPH  green lamp per phase
- YLW  out  NPH  yellow lamp per phase
- RED  out  NPH  red lamp per phase
- PHASE  out  $clog2(NPH)  index of the phase that owns right-of-way

## Operation
- The FSM has three states: S_GRN, S_YLW, S_AR. It uses a cur phase pointer, a TW-bit timer and an NPH-bit pending register.
- Tick generation:
  - The prescaler counts 0..PRE-1. tick=1 on the cycle the count equals PRE-1.
  - While TEST=1: tick=1 every cycle and the prescaler is held at 0.
- The timer advances only on a tick and resets to 0 on every state change.
- S_GRN, FM=0: on the tick where timer==T_GMAX-1 → S_YLW.
- S_GRN, FM=1:
  - Condition A: a tick with timer ≥ T_GMIN-1 and any pending bit set for a phase other than cur → S_YLW.
  - With no other pending bit: stay in S_GRN. The timer saturates at T_GMAX-1 and green rests indefinitely.
- S_YLW: on the tick where timer==T_YLW-1 → S_AR.
- S_AR: on the tick where timer==T_AR-1 → S_GRN with cur=next.
  - FM=0: next = (cur+1) mod NPH.
  - FM=1: next = first phase with a pending bit set, searching from cur+1 with wrap. If none is set, next = (cur+1) mod NPH.
- Pending register:
  - pending[i] sets on DEMAND[i]=1, except for i==cur while in S_GRN.
  - pending[cur] clears on entry to S_GRN.
  - If set and clear hit the same bit in one cycle, clear wins.
  - In FM=0 the register still latches but does not affect sequencing.
- Lamps:
  - S_GRN: GRN[cur]=1, RED on all other phases.
  - S_YLW: YLW[cur]=1, RED on all other phases.
  - S_AR: RED on all phases.
  - Exactly one lamp per phase is lit at all times.
- FM or TEST changing mid-phase takes effect at the next evaluation. A phase in progress is never truncated below T_YLW or T_AR.

## Timing
- Asynchronous CLR sets: state=S_GRN, cur=0, timer=0, prescaler=0, pending=0.
- Output values during and after CLR: GRN=1 (bit 0 only), YLW=0, RED=all ones except bit 0, PHASE=0.
- Outputs are registered and change on the same CK edge as the state register; no combinational path exists from input to output.
- DEMAND is visible in pending one cycle after being sampled.
- Fixed-mode phase period is (T_GMAX+T_YLW+T_AR)·PRE clocks. With TEST=1 it is T_GMAX+T_YLW+T_AR clocks.
- The transition out of a state occurs on the edge that ends its last tick. The first clock of the new state already shows the new lamps.
- A CLR asserted mid-phase takes effect immediately, regardless of tick alignment.

## Structure
- traffic_pkg holds:
  - the state typedef enum {S_GRN, S_YLW, S_AR};
  - the lamp-vector decode function;
  - the parameter legality checks as elaboration-time asserts.
- Sub-module tc_rr_pick is combinational: it takes the pending vector and cur and returns next plus a found flag.
- The prescaler, timer and FSM stay in traffic_ctrl_n.

## Test plan
- Defaults, TEST=1, FM=0, CLR pulse → GRN=01, RED=10. YLW[0] rises at cycle 32 and RED=11 at cycle 36. GRN[1] rises at cycle 37; phase 1 returns to phase 0 at cycle 74.
- TEST=0, PRE=16, FM=0 → first YLW[0] appears at CK 512 after CLR release.
- NPH=4, TEST=1, FM=1, no DEMAND → green rests on phase 0 for 200 cycles. Then a DEMAND[2] pulse at cycle 200 → YLW[0] on the next tick, then PHASE=2 with GRN=0100. Phases 1 and 3 are skipped.
- NPH=4, FM=1, DEMAND[3] at cycle 2 → green holds until cycle T_GMIN-1=7, then yellow. DEMAND[1] and DEMAND[3] both pending → phase 1 is served before phase 3.
- DEMAND[cur] during green → ignored. DEMAND[1] on the cycle phase 1 enters green → pending[1] ends at 0.
- CLR asserted during S_YLW of phase 1 → outputs return to the reset values asynchronously, and the sequence restarts from phase 0 green.
